// File: rtl/sequential_divider_if.sv
// sequential_divider_if: start/busy/done handshake plus operands and results of the divider
interface sequential_divider_if #(
    parameter int WIDTH_A = 16,
    parameter int WIDTH_B = 8
);
    logic               start;
    logic [WIDTH_A-1:0] a;
    logic [WIDTH_B-1:0] b;
    logic [WIDTH_A-1:0] q;
    logic [WIDTH_B-1:0] r;
    logic               busy;
    logic               done;
    logic               div_by_zero;

    modport master (output start, a, b, input q, r, busy, done, div_by_zero);
    modport slave  (input start, a, b, output q, r, busy, done, div_by_zero);
endinterface

// File: rtl/sequential_divider.sv
// sequential_divider: iterative restoring unsigned divider producing one quotient bit per clock
module sequential_divider #(
    parameter int WIDTH_A = 16,
    parameter int WIDTH_B = 8
) (
    input  logic clk,
    input  logic reset,
    sequential_divider_if.slave bus
);
    localparam int CW = $clog2(WIDTH_A + 1);

    typedef enum logic {IDLE, CALC} state_t;

    state_t             state_q, state_d;
    logic [WIDTH_A-1:0] dvd_q, dvd_d;
    logic [WIDTH_B-1:0] b_q, b_d;
    logic [WIDTH_B:0]   rem_q, rem_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH_A-1:0] q_q, q_d;
    logic [WIDTH_B-1:0] r_q, r_d;
    logic               done_q, done_d;
    logic               dbz_q, dbz_d;
    logic [WIDTH_B+1:0] trial;
    logic               ge;

    // State and datapath registers; reset aborts any division in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            dvd_q   <= '0;
            b_q     <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dvd_q   <= dvd_d;
            b_q     <= b_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            r_q     <= r_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
        end
    end

    // Accept/zero-divisor handling in IDLE, one restoring step per cycle in CALC
    always_comb begin
        state_d = state_q;
        dvd_d   = dvd_q;
        b_d     = b_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        r_d     = r_q;
        done_d  = 1'b0;
        dbz_d   = dbz_q;
        trial   = {rem_q, dvd_q[WIDTH_A-1]} - {2'b00, b_q};
        ge      = ~trial[WIDTH_B+1];
        if (state_q == IDLE) begin
            if (bus.start && bus.b != '0) begin
                state_d = CALC;
                dvd_d   = bus.a;
                b_d     = bus.b;
                rem_d   = '0;
                cnt_d   = CW'(WIDTH_A);
            end else if (bus.start) begin
                q_d    = '1;
                r_d    = '0;
                done_d = 1'b1;
                dbz_d  = 1'b1;
            end
        end else begin
            rem_d = ge ? trial[WIDTH_B:0] : {rem_q[WIDTH_B-1:0], dvd_q[WIDTH_A-1]};
            dvd_d = {dvd_q[WIDTH_A-2:0], ge};
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                state_d = IDLE;
                q_d     = dvd_d;
                r_d     = rem_d[WIDTH_B-1:0];
                done_d  = 1'b1;
                dbz_d   = 1'b0;
            end
        end
    end

    assign bus.busy        = (state_q == CALC);
    assign bus.done        = done_q;
    assign bus.q           = q_q;
    assign bus.r           = r_q;
    assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_sequential_divider.sv
// tb_sequential_divider: directed and random checks of the divider against a cycle-level arithmetic model
module tb_sequential_divider;
    localparam int WA = 16;
    localparam int WB = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;

    sequential_divider_if #(.WIDTH_A(WA), .WIDTH_B(WB)) bus ();

    sequential_divider #(.WIDTH_A(WA), .WIDTH_B(WB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Model: a division accepted when idle finishes WA edges later with a/b and a%b
    logic          m_busy, m_done, m_dbz;
    int            m_left;
    logic [WA-1:0] m_q, m_pq;
    logic [WB-1:0] m_r, m_pr;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_busy <= 1'b0; m_done <= 1'b0; m_dbz <= 1'b0; m_left <= 0;
            m_q <= '0; m_r <= '0; m_pq <= '0; m_pr <= '0;
        end else begin
            m_done <= 1'b0;
            if (!m_busy && bus.start && bus.b == 0) begin
                m_q <= '1; m_r <= '0; m_dbz <= 1'b1; m_done <= 1'b1;
            end else if (!m_busy && bus.start) begin
                m_busy <= 1'b1; m_left <= WA;
                m_pq <= bus.a / WA'(bus.b); m_pr <= WB'(bus.a % WA'(bus.b));
            end else if (m_busy) begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    m_busy <= 1'b0; m_q <= m_pq; m_r <= m_pr; m_dbz <= 1'b0; m_done <= 1'b1;
                end
            end
        end
    end

    // Cycle-by-cycle comparison of every output against the model
    always @(negedge clk) begin
        tests++;
        if ({bus.busy, bus.done, bus.div_by_zero, bus.q, bus.r} !== {m_busy, m_done, m_dbz, m_q, m_r}) begin
            fails++;
            $display("FAIL model cyc=%0d busy/done/dbz/q/r got %b%b%b %0d %0d want %b%b%b %0d %0d", cyc,
                     bus.busy, bus.done, bus.div_by_zero, bus.q, bus.r, m_busy, m_done, m_dbz, m_q, m_r);
        end
    end

    task automatic check(input bit ok, input string name, input int got, input int want);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL %s got %0d want %0d", name, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one start pulse, then wait (bounded) for done and check literal results and timing
    task automatic run(input logic [WA-1:0] a, input logic [WB-1:0] b, input logic [WA-1:0] eq,
                       input logic [WB-1:0] er, input bit edbz, input int elat, input string name);
        int lat;
        int bc;
        bus.start = 1'b1; bus.a = a; bus.b = b;
        tick();
        bus.start = 1'b0; bus.a = $urandom(); bus.b = WB'($urandom());
        lat = 0; bc = 0;
        while (!bus.done && lat < 40) begin
            if (bus.busy) bc++;
            tick();
            lat++;
        end
        check(lat == elat, {name, " latency"}, lat, elat);
        check(bc == elat, {name, " busy cycles"}, bc, elat);
        check(bus.q == eq, {name, " Q"}, int'(bus.q), int'(eq));
        check(bus.r == er, {name, " R"}, int'(bus.r), int'(er));
        check(bus.div_by_zero == edbz, {name, " div_by_zero"}, int'(bus.div_by_zero), int'(edbz));
        tick();
        check(bus.done == 1'b0, {name, " done single pulse"}, int'(bus.done), 0);
    endtask

    initial begin
        int dn[$];
        bit saw_done;
        logic [WA-1:0] ra;
        logic [WB-1:0] rb;
        bus.start = 1'b0; bus.a = '0; bus.b = '0;
        tick(); tick();
        check({bus.q, bus.r, bus.busy, bus.done, bus.div_by_zero} == '0, "reset outputs",
              int'(bus.q), 0);
        reset = 1'b0;
        tick();

        run(16'd1000, 8'd7, 16'd142, 8'd6, 1'b0, 16, "1000/7");
        run(16'd65535, 8'd1, 16'd65535, 8'd0, 1'b0, 16, "65535/1");
        run(16'd255, 8'd255, 16'd1, 8'd0, 1'b0, 16, "255/255");
        run(16'd100, 8'd200, 16'd0, 8'd100, 1'b0, 16, "100/200");
        run(16'd37887, 8'd219, 16'd173, 8'd0, 1'b0, 16, "roundtrip 173*219");
        run(16'd1234, 8'd0, 16'hFFFF, 8'd0, 1'b1, 0, "1234/0");
        run(16'd50, 8'd7, 16'd7, 8'd1, 1'b0, 16, "50/7 clears dbz");

        // Start during CALC with other operands is ignored
        bus.start = 1'b1; bus.a = 16'd1000; bus.b = 8'd7;
        tick();
        bus.start = 1'b0;
        repeat (4) tick();
        bus.start = 1'b1; bus.a = 16'd9; bus.b = 8'd3;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 30 && !bus.done; i++) tick();
        check(bus.q == 16'd142 && bus.r == 8'd6, "ignored start Q", int'(bus.q), 142);
        repeat (3) tick();

        // Start held high: accepts every WA+1 edges
        bus.start = 1'b1; bus.a = 16'd40000; bus.b = 8'd3;
        for (int i = 0; i < 55; i++) begin
            tick();
            if (bus.done) dn.push_back(cyc);
        end
        bus.start = 1'b0;
        check(dn.size() == 3, "held start done count", dn.size(), 3);
        if (dn.size() == 3) begin
            check(dn[1] - dn[0] == 17, "held start spacing 1", dn[1] - dn[0], 17);
            check(dn[2] - dn[1] == 17, "held start spacing 2", dn[2] - dn[1], 17);
        end
        check(bus.q == 16'd13333 && bus.r == 8'd1, "held start Q", int'(bus.q), 13333);
        repeat (20) tick();

        // Asynchronous reset mid-CALC
        bus.start = 1'b1; bus.a = 16'd999; bus.b = 8'd10;
        tick();
        bus.start = 1'b0;
        repeat (8) tick();
        #2 reset = 1'b1;
        #1;
        check({bus.q, bus.r, bus.busy, bus.done, bus.div_by_zero} == '0, "async reset outputs",
              int'(bus.busy), 0);
        tick();
        reset = 1'b0;
        saw_done = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.done) saw_done = 1'b1;
        end
        check(!saw_done, "no done after reset", int'(saw_done), 0);
        run(16'd999, 8'd10, 16'd99, 8'd9, 1'b0, 16, "after reset 999/10");

        for (int i = 0; i < 500; i++) begin
            ra = WA'($urandom_range(0, 65535));
            rb = WB'($urandom_range(1, 255));
            run(ra, rb, ra / WA'(rb), WB'(ra % WA'(rb)), 1'b0, 16, "random");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/sequential_divider.md
# sequential_divider

Iterative restoring divider: the inverse of the team's combinational 8x8 multiplier. It takes a WIDTH_A-bit unsigned dividend and a WIDTH_B-bit unsigned divisor, and produces quotient and remainder one bit per clock. A start/busy/done handshake lets it sit beside the multiplier in the arithmetic datapath. With default widths, feeding the multiplier's 16-bit product back in as dividend recovers the original 8-bit operand.

## Interface
- WIDTH_A, 16, dividend and quotient width; must be at least WIDTH_B.
- WIDTH_B, 8, divisor and remainder width; must be at least 1.
- clk  input  1  sole clock, rising edge.
- reset  input  1  asynchronous, active-high; forces the reset state immediately.
- start  input  1  request; sampled only in IDLE.
- A  input  WIDTH_A  unsigned dividend; sampled on the accepting edge only.
- B  input  WIDTH_B  unsigned divisor; sampled on the accepting edge only.
- Q  output  WIDTH_A  quotient, floor(A/B).
- R  output  WIDTH_B  remainder, A mod B.
- busy  output  1  high while a division is in progress.
- done  output  1  single-cycle pulse; Q and R are valid from this cycle on.
- div_by_zero  output  1  high together with done when the latched B was 0.

## Operation
- States: IDLE, CALC. DONE is not a state; done is a registered pulse.
- IDLE with start=1, B≠0:
  - latch A into the dividend shift register;
  - latch B;
  - clear the WIDTH_B+1-bit partial remainder;
  - load the bit counter with WIDTH_A;
  - go to CALC and set busy.
- IDLE with start=1, B=0:
  - stay IDLE and keep busy=0;
  - on that same edge set Q=all ones, R=0, done=1, div_by_zero=1.
- CALC, each edge:
  - shift {partial remainder, dividend} left by 1;
  - trial = partial remainder − B, computed at WIDTH_B+1 bits;
  - if trial ≥ 0: partial remainder = trial and the shifted-in quotient bit = 1;
  - otherwise: restore, and the quotient bit = 0;
  - decrement the counter.
- CALC, last iteration (counter 1 → 0):
  - write Q and R (the low WIDTH_B bits of the partial remainder; it is always < B);
  - done=1, div_by_zero=0, busy=0, return to IDLE.
- start while in CALC is ignored; no queuing. A and B changing during CALC have no effect.
- Q, R, and div_by_zero hold their values until the next completion, the next divide-by-zero, or reset.
- Arithmetic is unsigned throughout; there is no overflow case, since Q ≤ 2^WIDTH_A − 1.

## Timing
- Reset values: Q=0, R=0, busy=0, done=0, div_by_zero=0, state IDLE.
- Reset mid-CALC aborts the operation; no done pulse follows.
- For an accepting edge E0 with B≠0:
  - busy is high after E0 through E(WIDTH_A);
  - iterations occur on E1..E(WIDTH_A);
  - done is high for exactly one cycle after E(WIDTH_A), i.e. after E16 by default;
  - busy falls on the same edge that done rises.
- The earliest next accept is E(WIDTH_A+1); start may be held high continuously for back-to-back operations.
- Divide-by-zero: done and div_by_zero are high for one cycle after E0; latency is 1.
- done deasserts on the following edge whether or not start is high.

## Test plan
- A=1000, B=7, single start pulse -> done exactly 16 edges later, Q=142, R=6, div_by_zero=0; busy high for 16 cycles.
- A=65535, B=1 -> Q=65535, R=0. Then A=255, B=255 -> Q=1, R=0. Then A=100, B=200 -> Q=0, R=100.
- Multiplier round trip: C=173×219=37887 applied as A, B=219 -> Q=173, R=0. Also sweep 500 random (A, B≠0) pairs against a reference model.
- A=1234, B=0 -> after 1 edge: done=1, div_by_zero=1, Q=0xFFFF, R=0, busy never asserted. The next valid division then clears div_by_zero.
- Start raised again at cycle 5 of a busy division with different A/B -> ignored; the original result is delivered on schedule.
  - Start held high continuously -> a new accept every 17 edges.
- Reset asserted asynchronously mid-CALC (cycle 8) -> all outputs 0 immediately and no done pulse. A start after release completes normally.
